mc_controller: RTL and testbench

//   Multicycle main controller for the MIPS core: a Moore FSM plus ALU decoder that sequences
//   a shared-memory multicycle datapath (IR, A/B, ALUOut, MDR registers). Replaces the single-cycle

---
 rtl/mips_pkg.sv | 75 +++++++
 rtl/mc_controller_if.sv | 36 +++
 rtl/mc_aludec.sv | 34 +++
 rtl/mc_controller.sv | 176 +++++++++++++++++
 tb/tb_mc_controller.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs, ALU codes,
// controller state encodings, datapath select codes and the controller output bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWB = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JEX     = 4'd11;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       illegal;
        logic       ovf_exc;
        logic       mem_err;
    } ctrl_t;

    // States that hold a memory request open until mem_ready.
    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath/memory signal bundle. The controller is the master; the
// datapath side (IR fields, ALU flags, memory handshake) is the slave.
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;
    logic       mem_ready;
    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal;
    logic       ovf_exc;
    logic       mem_err;

    modport master (
        input  op, funct, zero, overflow, mem_ready,
        output mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
               alucontrol, regdst, memtoreg, regwrite, illegal, ovf_exc, mem_err
    );

    modport slave (
        output op, funct, zero, overflow, mem_ready,
        input  mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
               alucontrol, regdst, memtoreg, regwrite, illegal, ovf_exc, mem_err
    );
endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: maps the controller's aluop and the instruction funct field to an ALU
// control code, flagging undefined functs and the overflow-capable add/sub ops.
module mc_aludec
    import mips_pkg::*;
(
    input  aluop_e     i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alucontrol,
    output logic       o_illegal,
    output logic       o_addsub
);

    always_comb begin
        o_alucontrol = ALU_ADD;
        o_illegal    = 1'b0;
        o_addsub     = 1'b0;
        case (i_aluop)
            ALUOP_ADD: o_alucontrol = ALU_ADD;
            ALUOP_SUB: o_alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD: begin o_alucontrol = ALU_ADD; o_addsub = 1'b1; end
                    FN_SUB: begin o_alucontrol = ALU_SUB; o_addsub = 1'b1; end
                    FN_AND: o_alucontrol = ALU_AND;
                    FN_OR:  o_alucontrol = ALU_OR;
                    FN_SLT: o_alucontrol = ALU_SLT;
                    default: o_illegal = 1'b1;
                endcase
            end
            default: o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: Moore FSM sequencing a shared-memory datapath, with a
// bounded wait on the memory handshake and optional overflow write suppression.
module mc_controller
    import mips_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 16,
    parameter int OVF_TRAP     = 1
) (
    input  logic            clk,
    input  logic            rst,
    mc_controller_if.master bus
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    logic [3:0] r_state;
    logic [7:0] r_wait;
    logic       r_ovf;

    logic [3:0] w_state_next;
    ctrl_t      w_ctrl;
    aluop_e     w_aluop;
    logic [2:0] w_alucontrol;
    logic       w_illegal_funct;
    logic       w_addsub;
    logic       w_req;
    logic       w_timeout;
    logic       w_trap;

    assign w_req     = is_mem_state(r_state);
    assign w_timeout = w_req && !bus.mem_ready && (r_wait == WAIT_LAST);
    assign w_trap    = (OVF_TRAP != 0) && r_ovf;

    always_comb begin
        w_aluop = ALUOP_ADD;
        if (r_state == S_BEQEX)
            w_aluop = ALUOP_SUB;
        else if (r_state == S_RTYPEEX)
            w_aluop = ALUOP_FUNCT;
    end

    mc_aludec u_aludec (
        .i_aluop      (w_aluop),
        .i_funct      (bus.funct),
        .o_alucontrol (w_alucontrol),
        .o_illegal    (w_illegal_funct),
        .o_addsub     (w_addsub)
    );

    always_comb begin
        w_ctrl       = '0;
        w_state_next = r_state;
        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.alusrcb = SRCB_FOUR;
                w_ctrl.pcsrc   = PCSRC_ALU;
                if (bus.mem_ready) begin
                    w_ctrl.irwrite = 1'b1;
                    w_ctrl.pcwrite = 1'b1;
                    w_state_next   = S_DECODE;
                end else if (w_timeout) begin
                    // PC was not advanced, so the retry refetches the same address.
                    w_ctrl.mem_err = 1'b1;
                    w_state_next   = S_FETCH;
                end
            end
            S_DECODE: begin
                w_ctrl.alusrcb = SRCB_IMMSH;
                case (bus.op)
                    OP_LW, OP_SW: w_state_next = S_MEMADR;
                    OP_RTYPE:     w_state_next = S_RTYPEEX;
                    OP_BEQ:       w_state_next = S_BEQEX;
                    OP_ADDI:      w_state_next = S_ADDIEX;
                    OP_J:         w_state_next = S_JEX;
                    default: begin
                        w_ctrl.illegal = 1'b1;
                        w_state_next   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = SRCB_IMM;
                w_state_next   = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD, S_MEMWR: begin
                w_ctrl.mem_req  = 1'b1;
                w_ctrl.iord     = 1'b1;
                w_ctrl.memwrite = (r_state == S_MEMWR);
                if (bus.mem_ready) begin
                    w_state_next = (r_state == S_MEMRD) ? S_MEMWB : S_FETCH;
                end else if (w_timeout) begin
                    w_ctrl.mem_err = 1'b1;
                    w_state_next   = S_FETCH;
                end
            end
            S_MEMWB: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.memtoreg = 1'b1;
                w_state_next    = S_FETCH;
            end
            S_RTYPEEX: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = SRCB_B;
                if (w_illegal_funct) begin
                    w_ctrl.illegal = 1'b1;
                    w_state_next   = S_FETCH;
                end else begin
                    w_state_next   = S_RTYPEWB;
                end
            end
            S_RTYPEWB, S_ADDIWB: begin
                w_ctrl.regdst   = (r_state == S_RTYPEWB);
                w_ctrl.regwrite = !w_trap;
                w_ctrl.ovf_exc  = w_trap;
                w_state_next    = S_FETCH;
            end
            S_BEQEX: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = SRCB_B;
                w_ctrl.pcsrc   = PCSRC_ALUOUT;
                w_ctrl.branch  = 1'b1;
                w_state_next   = S_FETCH;
            end
            S_ADDIEX: begin
                w_ctrl.alusrca = 1'b1;
                w_ctrl.alusrcb = SRCB_IMM;
                w_state_next   = S_ADDIWB;
            end
            S_JEX: begin
                w_ctrl.pcsrc   = PCSRC_JUMP;
                w_ctrl.pcwrite = 1'b1;
                w_state_next   = S_FETCH;
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
            r_wait  <= 8'd0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((w_state_next != r_state) || w_timeout)
                r_wait <= 8'd0;
            else if (w_req && !bus.mem_ready)
                r_wait <= r_wait + 8'd1;
            // Only add/sub/addi can raise a meaningful overflow for the following writeback.
            if ((r_state == S_RTYPEEX && w_addsub) || (r_state == S_ADDIEX))
                r_ovf <= bus.overflow;
            else
                r_ovf <= 1'b0;
        end
    end

    // Outputs are forced low combinationally so nothing leaks while reset is held.
    assign bus.mem_req    = rst & w_ctrl.mem_req;
    assign bus.memwrite   = rst & w_ctrl.memwrite;
    assign bus.iord       = rst & w_ctrl.iord;
    assign bus.irwrite    = rst & w_ctrl.irwrite;
    assign bus.pcen       = rst & (w_ctrl.pcwrite | (w_ctrl.branch & bus.zero));
    assign bus.pcsrc      = rst ? w_ctrl.pcsrc : 2'b00;
    assign bus.alusrca    = rst & w_ctrl.alusrca;
    assign bus.alusrcb    = rst ? w_ctrl.alusrcb : 2'b00;
    assign bus.alucontrol = rst ? w_alucontrol : 3'b000;
    assign bus.regdst     = rst & w_ctrl.regdst;
    assign bus.memtoreg   = rst & w_ctrl.memtoreg;
    assign bus.regwrite   = rst & w_ctrl.regwrite;
    assign bus.illegal    = rst & w_ctrl.illegal;
    assign bus.ovf_exc    = rst & w_ctrl.ovf_exc;
    assign bus.mem_err    = rst & w_ctrl.mem_err;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle stimulus tables with hand-computed output vectors.
module tb_mc_controller;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mc_controller_if bus();

    mc_controller #(.MEM_WAIT_MAX(16), .OVF_TRAP(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mem_req,memwrite,iord,irwrite,pcen,pcsrc,alusrca,alusrcb,alucontrol,
    //  regdst,memtoreg,regwrite,illegal,ovf_exc,mem_err}
    logic [18:0] obs;
    assign obs = {bus.mem_req, bus.memwrite, bus.iord, bus.irwrite, bus.pcen, bus.pcsrc,
                  bus.alusrca, bus.alusrcb, bus.alucontrol, bus.regdst, bus.memtoreg,
                  bus.regwrite, bus.illegal, bus.ovf_exc, bus.mem_err};

    localparam logic [18:0] E_FETCH_W    = {5'b10000, 2'b00, 1'b0, 2'b01, 3'b010, 6'b000000};
    localparam logic [18:0] E_FETCH_R    = {5'b10011, 2'b00, 1'b0, 2'b01, 3'b010, 6'b000000};
    localparam logic [18:0] E_FETCH_ERR  = {5'b10000, 2'b00, 1'b0, 2'b01, 3'b010, 6'b000001};
    localparam logic [18:0] E_DECODE     = {5'b00000, 2'b00, 1'b0, 2'b11, 3'b010, 6'b000000};
    localparam logic [18:0] E_DEC_ILL    = {5'b00000, 2'b00, 1'b0, 2'b11, 3'b010, 6'b000100};
    localparam logic [18:0] E_MEMADR     = {5'b00000, 2'b00, 1'b1, 2'b10, 3'b010, 6'b000000};
    localparam logic [18:0] E_MEMRD      = {5'b10100, 2'b00, 1'b0, 2'b00, 3'b010, 6'b000000};
    localparam logic [18:0] E_MEMWR      = {5'b11100, 2'b00, 1'b0, 2'b00, 3'b010, 6'b000000};
    localparam logic [18:0] E_MEMWR_ERR  = {5'b11100, 2'b00, 1'b0, 2'b00, 3'b010, 6'b000001};
    localparam logic [18:0] E_MEMWB      = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b010, 6'b011000};
    localparam logic [18:0] E_RTEX_ADD   = {5'b00000, 2'b00, 1'b1, 2'b00, 3'b010, 6'b000000};
    localparam logic [18:0] E_RTEX_ILL   = {5'b00000, 2'b00, 1'b1, 2'b00, 3'b010, 6'b000100};
    localparam logic [18:0] E_RTWB       = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b010, 6'b101000};
    localparam logic [18:0] E_RTWB_OVF   = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b010, 6'b100010};
    localparam logic [18:0] E_ADDIEX     = {5'b00000, 2'b00, 1'b1, 2'b10, 3'b010, 6'b000000};
    localparam logic [18:0] E_ADDIWB     = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b010, 6'b001000};
    localparam logic [18:0] E_ADDIWB_OVF = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b010, 6'b000010};
    localparam logic [18:0] E_BEQ_T      = {5'b00001, 2'b01, 1'b1, 2'b00, 3'b110, 6'b000000};
    localparam logic [18:0] E_BEQ_F      = {5'b00000, 2'b01, 1'b1, 2'b00, 3'b110, 6'b000000};
    localparam logic [18:0] E_JEX        = {5'b00001, 2'b10, 1'b0, 2'b00, 3'b010, 6'b000000};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

    typedef struct packed {
        logic        rdy;
        logic        zero;
        logic        ovf;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [18:0] exp;
    } step_t;

    function automatic step_t mk(input logic rdy, input logic zero, input logic ovf,
                                 input logic [5:0] op, input logic [5:0] funct,
                                 input logic [18:0] e);
        step_t s;
        s.rdy = rdy; s.zero = zero; s.ovf = ovf; s.op = op; s.funct = funct; s.exp = e;
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        bus.mem_ready = 1'b1; bus.zero = 1'b1; bus.overflow = 1'b1;
        bus.op = JMP; bus.funct = 6'b100000;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", obs, 19'd0);
        end
        bus.mem_ready = 1'b0; bus.zero = 1'b0; bus.overflow = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== E_FETCH_W) begin
            failures++;
            $display("FAIL reset_release_fetch got=%b exp=%b", obs, E_FETCH_W);
        end
    endtask

    task automatic test_lw();
        step_t q[$];
        q.push_back(mk(1, 0, 0, LW, 0, E_FETCH_R));
        q.push_back(mk(0, 0, 0, LW, 0, E_DECODE));
        q.push_back(mk(0, 0, 0, LW, 0, E_MEMADR));
        q.push_back(mk(1, 0, 0, LW, 0, E_MEMRD));
        q.push_back(mk(0, 0, 0, LW, 0, E_MEMWB));
        q.push_back(mk(0, 0, 0, LW, 0, E_FETCH_W));
        foreach (q[i]) begin
            bus.mem_ready = q[i].rdy; bus.zero = q[i].zero; bus.overflow = q[i].ovf;
            bus.op = q[i].op; bus.funct = q[i].funct;
            #1;
            checks++;
            if (obs !== q[i].exp) begin
                failures++;
                $display("FAIL lw step=%0d got=%b exp=%b", i, obs, q[i].exp);
            end
            if (i != q.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_rtype_ovf();
        step_t q[$];
        q.push_back(mk(1, 0, 0, RT, 6'b100000, E_FETCH_R));
        q.push_back(mk(0, 0, 0, RT, 6'b100000, E_DECODE));
        q.push_back(mk(0, 0, 1, RT, 6'b100000, E_RTEX_ADD));
        q.push_back(mk(0, 0, 0, RT, 6'b100000, E_RTWB_OVF));
        q.push_back(mk(1, 0, 0, RT, 6'b100000, E_FETCH_R));
        q.push_back(mk(0, 0, 1, RT, 6'b100000, E_DECODE));
        q.push_back(mk(0, 0, 0, RT, 6'b100000, E_RTEX_ADD));
        q.push_back(mk(0, 0, 1, RT, 6'b100000, E_RTWB));
        q.push_back(mk(0, 0, 0, RT, 6'b100000, E_FETCH_W));
        foreach (q[i]) begin
            bus.mem_ready = q[i].rdy; bus.zero = q[i].zero; bus.overflow = q[i].ovf;
            bus.op = q[i].op; bus.funct = q[i].funct;
            #1;
            checks++;
            if (obs !== q[i].exp) begin
                failures++;
                $display("FAIL rtype_ovf step=%0d got=%b exp=%b", i, obs, q[i].exp);
            end
            if (i != q.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    // Overflow is asserted for every funct; only sub may trap among these.
    task automatic test_alu_funct();
        step_t q[$];
        logic [5:0]  fn  [4] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0]  alu [4] = '{3'b110, 3'b000, 3'b001, 3'b111};
        logic [18:0] wb  [4] = '{E_RTWB_OVF, E_RTWB, E_RTWB, E_RTWB};
        for (int k = 0; k < 4; k++) begin
            q.push_back(mk(1, 0, 1, RT, fn[k], E_FETCH_R));
            q.push_back(mk(0, 0, 1, RT, fn[k], E_DECODE));
            q.push_back(mk(0, 0, 1, RT, fn[k],
                           {5'b00000, 2'b00, 1'b1, 2'b00, alu[k], 6'b000000}));
            q.push_back(mk(0, 0, 1, RT, fn[k], wb[k]));
        end
        q.push_back(mk(0, 0, 0, RT, 6'b100000, E_FETCH_W));
        foreach (q[i]) begin
            bus.mem_ready = q[i].rdy; bus.zero = q[i].zero; bus.overflow = q[i].ovf;
            bus.op = q[i].op; bus.funct = q[i].funct;
            #1;
            checks++;
            if (obs !== q[i].exp) begin
                failures++;
                $display("FAIL alu_funct step=%0d got=%b exp=%b", i, obs, q[i].exp);
            end
            if (i != q.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_addi();
        step_t q[$];
        q.push_back(mk(1, 0, 0, ADDI, 0, E_FETCH_R));
        q.push_back(mk(0, 0, 0, ADDI, 0, E_DECODE));
        q.push_back(mk(0, 0, 1, ADDI, 0, E_ADDIEX));
        q.push_back(mk(0, 0, 0, ADDI, 0, E_ADDIWB_OVF));
        q.push_back(mk(1, 0, 0, ADDI, 0, E_FETCH_R));
        q.push_back(mk(0, 0, 0, ADDI, 0, E_DECODE));
        q.push_back(mk(0, 0, 0, ADDI, 0, E_ADDIEX));
        q.push_back(mk(0, 0, 0, ADDI, 0, E_ADDIWB));
        q.push_back(mk(0, 0, 0, ADDI, 0, E_FETCH_W));
        foreach (q[i]) begin
            bus.mem_ready = q[i].rdy; bus.zero = q[i].zero; bus.overflow = q[i].ovf;
            bus.op = q[i].op; bus.funct = q[i].funct;
            #1;
            checks++;
            if (obs !== q[i].exp) begin
                failures++;
                $display("FAIL addi step=%0d got=%b exp=%b", i, obs, q[i].exp);
            end
            if (i != q.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_branch_jump();
        step_t q[$];
        q.push_back(mk(1, 0, 0, BEQ, 0, E_FETCH_R));
        q.push_back(mk(0, 0, 0, BEQ, 0, E_DECODE));
        q.push_back(mk(0, 1, 0, BEQ, 0, E_BEQ_T));
        q.push_back(mk(1, 0, 0, BEQ, 0, E_FETCH_R));
        q.push_back(mk(0, 1, 0, BEQ, 0, E_DECODE));
        q.push_back(mk(0, 0, 0, BEQ, 0, E_BEQ_F));
        q.push_back(mk(1, 0, 0, JMP, 0, E_FETCH_R));
        q.push_back(mk(0, 0, 0, JMP, 0, E_DECODE));
        q.push_back(mk(0, 0, 0, JMP, 0, E_JEX));
        q.push_back(mk(0, 0, 0, JMP, 0, E_FETCH_W));
        foreach (q[i]) begin
            bus.mem_ready = q[i].rdy; bus.zero = q[i].zero; bus.overflow = q[i].ovf;
            bus.op = q[i].op; bus.funct = q[i].funct;
            #1;
            checks++;
            if (obs !== q[i].exp) begin
                failures++;
                $display("FAIL branch_jump step=%0d got=%b exp=%b", i, obs, q[i].exp);
            end
            if (i != q.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_illegal();
        step_t q[$];
        q.push_back(mk(1, 0, 0, 6'b111111, 0, E_FETCH_R));
        q.push_back(mk(0, 0, 0, 6'b111111, 0, E_DEC_ILL));
        q.push_back(mk(1, 0, 0, RT, 6'b000111, E_FETCH_R));
        q.push_back(mk(0, 0, 0, RT, 6'b000111, E_DECODE));
        q.push_back(mk(0, 0, 1, RT, 6'b000111, E_RTEX_ILL));
        q.push_back(mk(0, 0, 0, RT, 6'b000111, E_FETCH_W));
        foreach (q[i]) begin
            bus.mem_ready = q[i].rdy; bus.zero = q[i].zero; bus.overflow = q[i].ovf;
            bus.op = q[i].op; bus.funct = q[i].funct;
            #1;
            checks++;
            if (obs !== q[i].exp) begin
                failures++;
                $display("FAIL illegal step=%0d got=%b exp=%b", i, obs, q[i].exp);
            end
            if (i != q.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_sw_wait();
        step_t q[$];
        q.push_back(mk(1, 0, 0, SW, 0, E_FETCH_R));
        q.push_back(mk(0, 0, 0, SW, 0, E_DECODE));
        q.push_back(mk(0, 0, 0, SW, 0, E_MEMADR));
        for (int k = 0; k < 3; k++) q.push_back(mk(0, 0, 0, SW, 0, E_MEMWR));
        q.push_back(mk(1, 0, 0, SW, 0, E_MEMWR));
        q.push_back(mk(1, 0, 0, SW, 0, E_FETCH_R));
        q.push_back(mk(0, 0, 0, SW, 0, E_DECODE));
        q.push_back(mk(0, 0, 0, SW, 0, E_MEMADR));
        for (int k = 0; k < 15; k++) q.push_back(mk(0, 0, 0, SW, 0, E_MEMWR));
        q.push_back(mk(0, 0, 0, SW, 0, E_MEMWR_ERR));
        q.push_back(mk(0, 0, 0, SW, 0, E_FETCH_W));
        foreach (q[i]) begin
            bus.mem_ready = q[i].rdy; bus.zero = q[i].zero; bus.overflow = q[i].ovf;
            bus.op = q[i].op; bus.funct = q[i].funct;
            #1;
            checks++;
            if (obs !== q[i].exp) begin
                failures++;
                $display("FAIL sw_wait step=%0d got=%b exp=%b", i, obs, q[i].exp);
            end
            if (i != q.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    // Fetch times out after 16 idle cycles, then a ready arriving exactly at the limit wins.
    task automatic test_fetch_timeout();
        step_t q[$];
        for (int k = 0; k < 15; k++) q.push_back(mk(0, 0, 0, JMP, 0, E_FETCH_W));
        q.push_back(mk(0, 0, 0, JMP, 0, E_FETCH_ERR));
        for (int k = 0; k < 15; k++) q.push_back(mk(0, 0, 0, JMP, 0, E_FETCH_W));
        q.push_back(mk(1, 0, 0, JMP, 0, E_FETCH_R));
        q.push_back(mk(0, 0, 0, JMP, 0, E_DECODE));
        q.push_back(mk(0, 0, 0, JMP, 0, E_JEX));
        q.push_back(mk(0, 0, 0, SW, 0, E_FETCH_W));
        foreach (q[i]) begin
            bus.mem_ready = q[i].rdy; bus.zero = q[i].zero; bus.overflow = q[i].ovf;
            bus.op = q[i].op; bus.funct = q[i].funct;
            #1;
            checks++;
            if (obs !== q[i].exp) begin
                failures++;
                $display("FAIL fetch_timeout step=%0d got=%b exp=%b", i, obs, q[i].exp);
            end
            if (i != q.size() - 1) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset_mid();
        step_t q[$];
        q.push_back(mk(1, 0, 0, SW, 0, E_FETCH_R));
        q.push_back(mk(0, 0, 0, SW, 0, E_DECODE));
        q.push_back(mk(0, 0, 0, SW, 0, E_MEMADR));
        q.push_back(mk(0, 0, 0, SW, 0, E_MEMWR));
        foreach (q[i]) begin
            bus.mem_ready = q[i].rdy; bus.zero = q[i].zero; bus.overflow = q[i].ovf;
            bus.op = q[i].op; bus.funct = q[i].funct;
            #1;
            checks++;
            if (obs !== q[i].exp) begin
                failures++;
                $display("FAIL reset_mid step=%0d got=%b exp=%b", i, obs, q[i].exp);
            end
            if (i != q.size() - 1) begin @(posedge clk); #1; end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 19'd0) begin
            failures++;
            $display("FAIL reset_mid_immediate got=%b exp=%b", obs, 19'd0);
        end
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs !== 19'd0) begin
            failures++;
            $display("FAIL reset_mid_held got=%b exp=%b", obs, 19'd0);
        end
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== E_FETCH_W) begin
            failures++;
            $display("FAIL reset_mid_release got=%b exp=%b", obs, E_FETCH_W);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        bus.op = 6'd0; bus.funct = 6'd0;
        bus.zero = 1'b0; bus.overflow = 1'b0; bus.mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_rtype_ovf();
        test_alu_funct();
        test_addi();
        test_branch_jump();
        test_illegal();
        test_sw_wait();
        test_fetch_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
